// File: rtl/mul_div_if.sv
// Operand/request and HI/LO result bundle between the register-file read side and the mul/div unit.
interface mul_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO unit: radix-2 shift-add multiply and restoring divide on magnitudes,
// with sign correction applied in a single FIX cycle before HI/LO are written.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r, dz, done_q;
  logic [WIDTH-1:0] opnd, hi_q, lo_q;
  logic [W2-1:0]    acc, acc_n;

  logic             start_md, sgn_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH:0]   msum, dtrial;
  logic [W2-1:0]    prod_fix;

  assign start_md = (state == IDLE) && bus.start && !bus.op[2];
  assign sgn_op   = !bus.op[0];
  assign sa       = sgn_op & bus.a[WIDTH-1];
  assign sb       = sgn_op & bus.b[WIDTH-1];
  assign mag_a    = sa ? (~bus.a + 1'b1) : bus.a;
  assign mag_b    = sb ? (~bus.b + 1'b1) : bus.b;

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  always_comb begin
    msum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    dtrial = acc[W2-1:WIDTH-1] - {1'b0, opnd};
    if (!is_div)
      acc_n = {msum, acc[WIDTH-1:1]};
    else if (!dtrial[WIDTH])
      acc_n = {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_n = {acc[W2-2:0], 1'b0};
  end

  // Divide-by-zero leaves |a| as remainder, so restoring the dividend sign yields a itself
  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    q_fix    = (neg_q && !dz) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    r_fix    = neg_r ? (~acc[W2-1:WIDTH] + 1'b1) : acc[W2-1:WIDTH];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_md) state_n = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_md) begin
            is_div <= bus.op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= (bus.b == '0);
            opnd   <= bus.op[1] ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            cnt    <= '0;
          end else if (bus.start && bus.op == 3'b100) begin
            hi_q <= bus.a;
          end else if (bus.start && bus.op == 3'b101) begin
            lo_q <= bus.a;
          end
        end
        CALC: begin
          acc <= acc_n;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Random and directed stimulus for mul_div_unit, checked every cycle against a transaction-level HI/LO model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mul_div_if #(.WIDTH(32)) bus();

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: results computed with plain 64-bit arithmetic, visible 33 edges after acceptance
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_rem;
  logic        m_done;

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi <= '0; m_lo <= '0; m_pend <= '0; m_rem <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (bus.start) begin
          if (bus.op == 3'd4) m_hi <= bus.a;
          else if (bus.op == 3'd5) m_lo <= bus.a;
          else if (bus.op < 3'd4) begin
            m_pend <= ref_op(bus.op, bus.a, bus.b);
            m_rem  <= 33;
          end
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_rem != 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bcnt;
    bit got;
    bcnt = 0;
    got = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.busy) bcnt++;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd33);
    chk({nm, "_hi"}, bus.hi, exp_hi);
    chk({nm, "_lo"}, bus.lo, exp_lo);
    chk({nm, "_model_hi"}, m_hi, exp_hi);
    chk({nm, "_model_lo"}, m_lo, exp_lo);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    do_op("divu_z", 3'd3, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    do_op("div_z", 3'd2, 32'h8765_4321, 32'h0, 32'h8765_4321, 32'hFFFF_FFFF);

    // MTHI is immediate and never raises busy/done
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA_5555;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mthi_hi", bus.hi, 32'hAAAA_5555);
    chk("mthi_busy", 32'(bus.busy), 32'd0);

    // MTLO while busy must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0000_DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
    chk("mtlo_busy_done", 32'(bus.done), 32'd1);
    chk("mtlo_busy_hi", bus.hi, 32'd0);
    chk("mtlo_busy_lo", bus.lo, 32'd15);

    // Asynchronous reset mid-divide
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op("divu_after_rst", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // Random traffic, including requests while busy and no-op codes
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: begin bus.a = 32'h8000_0000; bus.b = 32'hFFFF_FFFF; end
        1: begin bus.a = $urandom; bus.b = 32'h0; end
        2: begin bus.a = 32'($urandom_range(0, 300)); bus.b = 32'($urandom_range(1, 20)); end
        default: begin bus.a = $urandom; bus.b = $urandom; end
      endcase
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
